// File: rtl/peb_rs232_pkg.sv
// Shared constants and state types for the PEB RS232 card.
package peb_rs232_pkg;

  // CRU bit numbers
  localparam logic [4:0] XBR_LOAD  = 5'd7;
  localparam logic [4:0] FE        = 5'd9;
  localparam logic [4:0] RATE_LOAD = 5'd10;
  localparam logic [4:0] LDRR      = 5'd12;
  localparam logic [4:0] RIN       = 5'd15;
  localparam logic [4:0] RINT      = 5'd16;
  localparam logic [4:0] RIENB     = 5'd18;
  localparam logic [4:0] RBRL      = 5'd21;
  localparam logic [4:0] XBRE      = 5'd22;
  localparam logic [4:0] XSRE      = 5'd23;
  localparam logic [4:0] INT_RESET = 5'd31;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Ticks in one bit period for a given divisor.
  function automatic logic [11:0] bit_ticks(input logic [10:0] rate);
    return {1'b0, rate} + 12'd1;
  endfunction

endpackage

// File: rtl/peb_rs232_rx.sv
// 8N1 receiver: input synchroniser, start-bit qualification, data and stop sampling.
module peb_rs232_rx
  import peb_rs232_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        tick_i,
  input  logic [10:0] rate_i,
  input  logic        rxd_i,
  output logic        rxd_sync_o,
  output logic        done_o,
  output logic [7:0]  data_o,
  output logic        frame_err_o
);

  logic        sync1_q, sync2_q, prev_q;
  rx_state_e   state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] full_ticks;
  logic        bit_end;

  assign full_ticks = bit_ticks(rate_i);
  // Counter is loaded at each bit start and the event fires on the tick that empties it.
  assign bit_end    = tick_i && (cnt_q <= 12'd1);
  assign rxd_sync_o = sync2_q;
  assign data_o     = shift_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clr_i) begin
        state_q <= RxIdle;
        cnt_q   <= '0;
        idx_q   <= '0;
        shift_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        shift_q <= shift_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_o      = 1'b0;
    frame_err_o = 1'b0;

    if (state_q != RxIdle && tick_i && cnt_q > 12'd1) begin
      cnt_d = cnt_q - 12'd1;
    end

    unique case (state_q)
      RxIdle: begin
        if (prev_q && !sync2_q) begin
          state_d = RxStart;
          cnt_d   = full_ticks >> 1;
        end
      end
      RxStart: begin
        if (bit_end) begin
          if (sync2_q) begin
            state_d = RxIdle;
          end else begin
            state_d = RxData;
            cnt_d   = full_ticks;
            idx_d   = '0;
          end
        end
      end
      RxData: begin
        if (bit_end) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = full_ticks;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = RxStop;
          end
        end
      end
      RxStop: begin
        if (bit_end) begin
          done_o      = 1'b1;
          frame_err_o = !sync2_q;
          state_d     = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/peb_rs232.sv
// Simplified TMS9902-style serial card on the CRU: decode, registers and transmitter.
// a[0] here is the CPU's a15 (CRU output data); a[15:1] carry a0..a14.
module peb_rs232
  import peb_rs232_pkg::*;
#(
  parameter logic [15:0] CRU_BASE   = 16'h1340,
  parameter logic [10:0] RATE_RESET = 11'd25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_3mhz_en,
  input  logic [15:0] a,
  input  logic        cruclk,
  output logic        cruin,
  output logic        cru_select,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  logic [14:0] off;
  logic [4:0]  bit_num;
  logic        cruclk_q;
  logic        wr, wdata, soft_rst;

  logic [10:0] hold_q, hold_d;
  logic [10:0] rate_q, rate_d;
  logic        ldrr_q, ldrr_d;
  logic [7:0]  xbr_q, xbr_d;
  logic        xbr_wr;
  logic        xbre_q, xbre_d;
  logic        xsre_q, xsre_d;
  logic [7:0]  rbr_q, rbr_d;
  logic        rbrl_q, rbrl_d;
  logic        rint_q, rint_d;
  logic        rienb_q, rienb_d;
  logic        fe_q, fe_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_load, tx_bit_end;
  logic [11:0] full_ticks;

  logic        rx_sync, rx_done, rx_fe;
  logic [7:0]  rx_data;
  logic        rd_bit;

  // Word offset from the card base; anything outside 0..31 wraps into the upper bits.
  assign off        = a[15:1] - CRU_BASE[15:1];
  assign cru_select = (off[14:5] == '0);
  assign bit_num    = off[4:0];
  assign wdata      = a[0];
  assign wr         = cruclk && !cruclk_q && cru_select;
  assign soft_rst   = wr && (bit_num == INT_RESET);

  assign irq        = rint_q && rienb_q;
  assign full_ticks = bit_ticks(rate_q);
  assign tx_bit_end = clk_3mhz_en && (tx_cnt_q <= 12'd1);

  peb_rs232_rx u_rx (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .clr_i       (soft_rst),
    .tick_i      (clk_3mhz_en),
    .rate_i      (rate_q),
    .rxd_i       (rxd),
    .rxd_sync_o  (rx_sync),
    .done_o      (rx_done),
    .data_o      (rx_data),
    .frame_err_o (rx_fe)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cruclk_q   <= 1'b0;
      rate_q     <= RATE_RESET;
      hold_q     <= '0;
      ldrr_q     <= 1'b0;
      xbr_q      <= '0;
      xbre_q     <= 1'b1;
      xsre_q     <= 1'b1;
      rbr_q      <= '0;
      rbrl_q     <= 1'b0;
      rint_q     <= 1'b0;
      rienb_q    <= 1'b0;
      fe_q       <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      cruclk_q <= cruclk;
      rate_q   <= rate_d;
      if (soft_rst) begin
        hold_q     <= '0;
        ldrr_q     <= 1'b0;
        xbr_q      <= '0;
        xbre_q     <= 1'b1;
        xsre_q     <= 1'b1;
        rbr_q      <= '0;
        rbrl_q     <= 1'b0;
        rint_q     <= 1'b0;
        rienb_q    <= 1'b0;
        fe_q       <= 1'b0;
        tx_state_q <= TxIdle;
        tx_cnt_q   <= '0;
        tx_idx_q   <= '0;
        tx_shift_q <= '0;
      end else begin
        hold_q     <= hold_d;
        ldrr_q     <= ldrr_d;
        xbr_q      <= xbr_d;
        xbre_q     <= xbre_d;
        xsre_q     <= xsre_d;
        rbr_q      <= rbr_d;
        rbrl_q     <= rbrl_d;
        rint_q     <= rint_d;
        rienb_q    <= rienb_d;
        fe_q       <= fe_d;
        tx_state_q <= tx_state_d;
        tx_cnt_q   <= tx_cnt_d;
        tx_idx_q   <= tx_idx_d;
        tx_shift_q <= tx_shift_d;
      end
    end
  end

  // CRU writes and receive completion
  always_comb begin
    hold_d  = hold_q;
    rate_d  = rate_q;
    ldrr_d  = ldrr_q;
    xbr_d   = xbr_q;
    xbr_wr  = 1'b0;
    rbr_d   = rbr_q;
    rbrl_d  = rbrl_q;
    rint_d  = rint_q;
    rienb_d = rienb_q;
    fe_d    = fe_q;

    if (wr) begin
      if (bit_num <= RATE_LOAD) begin
        hold_d[bit_num[3:0]] = wdata;
        if (ldrr_q && bit_num == RATE_LOAD) begin
          rate_d = hold_d;
          ldrr_d = 1'b0;
        end else if (!ldrr_q && bit_num == XBR_LOAD) begin
          xbr_d  = hold_d[7:0];
          xbr_wr = 1'b1;
        end
      end
      if (bit_num == LDRR) begin
        ldrr_d = wdata;
      end
      if (bit_num == RIENB) begin
        rbrl_d  = 1'b0;
        rint_d  = 1'b0;
        rienb_d = wdata;
      end
    end

    // Placed after the write so a completing character beats a same-cycle clear.
    if (rx_done) begin
      rbr_d  = rx_data;
      fe_d   = rx_fe;
      rbrl_d = 1'b1;
      rint_d = 1'b1;
    end
  end

  // Transmitter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    xbre_d     = xbre_q;
    xsre_d     = xsre_q;
    tx_load    = 1'b0;

    if (tx_state_q != TxIdle && clk_3mhz_en && tx_cnt_q > 12'd1) begin
      tx_cnt_d = tx_cnt_q - 12'd1;
    end

    unique case (tx_state_q)
      TxIdle: begin
        if (!xbre_q) begin
          tx_load = 1'b1;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_cnt_d   = full_ticks;
          tx_idx_d   = '0;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_cnt_d   = full_ticks;
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TxStop;
          end
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (!xbre_q) begin
            tx_load = 1'b1;
          end else begin
            xsre_d     = 1'b1;
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    if (tx_load) begin
      tx_shift_d = xbr_q;
      tx_cnt_d   = full_ticks;
      tx_state_d = TxStart;
      xbre_d     = 1'b1;
      xsre_d     = 1'b0;
    end
    // A fresh buffer write leaves a pending character even if the old one just loaded.
    if (xbr_wr) begin
      xbre_d = 1'b0;
    end
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart: txd = 1'b0;
      TxData:  txd = tx_shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    rd_bit = 1'b0;
    if (bit_num <= 5'd7) begin
      rd_bit = rbr_q[bit_num[2:0]];
    end else begin
      case (bit_num)
        FE:        rd_bit = fe_q;
        RIN:       rd_bit = rx_sync;
        RINT:      rd_bit = rint_q;
        RBRL:      rd_bit = rbrl_q;
        XBRE:      rd_bit = xbre_q;
        XSRE:      rd_bit = xsre_q;
        INT_RESET: rd_bit = irq;
        default:   rd_bit = 1'b0;
      endcase
    end
  end

  assign cruin = cru_select && rd_bit;

endmodule

// File: tb/tb_peb_rs232.sv
// Randomised bench for peb_rs232: serial frames are decoded/driven by the bench and scored.
module tb_peb_rs232;

  localparam logic [15:0] Base = 16'h1340;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_3mhz_en = 1'b0;
  logic [15:0] a = Base;
  logic        cruclk = 1'b0;
  logic        rxd = 1'b1;
  logic        cruin, cru_select, txd, irq;

  peb_rs232 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_3mhz_en (clk_3mhz_en),
    .a           (a),
    .cruclk      (cruclk),
    .cruin       (cruin),
    .cru_select  (cru_select),
    .rxd         (rxd),
    .txd         (txd),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_div = 0;
  event tick_ev;
  int   tb_rate = 25;
  logic tb_rienb = 1'b0;
  bit   mon_flush = 1'b0;

  typedef struct packed {logic [7:0] data; logic b2b;} tx_exp_t;
  typedef struct packed {logic [7:0] data; logic fe;} rx_exp_t;
  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  // One enable every 4 system clocks, changed away from the active edge.
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % 4;
    clk_3mhz_en = (tick_div == 0);
    if (clk_3mhz_en) ->tick_ev;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(tick_ev);
  endtask

  // ---------------- TX monitor: samples txd once per tick ----------------
  logic smp[$];
  int   idle_run = 0;
  int   gap = 0;

  task automatic decode_frame();
    int       w;
    logic [9:0] bits;
    logic     wide_ok;
    logic     gap_ok;
    tx_exp_t  e;
    w = tb_rate + 1;
    wide_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bits[k] = smp[k*w];
      for (int j = 1; j < w; j++) if (smp[k*w+j] !== bits[k]) wide_ok = 1'b0;
    end
    smp.delete();
    if (tx_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_unexpected_frame: got frame bits %0h, expected no frame", bits);
    end else begin
      e = tx_q.pop_front();
      gap_ok = !e.b2b || (gap == 0);
      check("tx_frame{width_ok,gap_ok,stop,data,start}", {wide_ok, gap_ok, bits},
            {1'b1, 1'b1, 1'b1, e.data, 1'b0});
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_flush) begin
      smp.delete();
      tx_q.delete();
      idle_run  = 0;
      mon_flush = 1'b0;
    end else if (clk_3mhz_en && reset_n) begin
      if (smp.size() == 0 && txd) begin
        idle_run++;
      end else begin
        if (smp.size() == 0) begin
          gap = idle_run;
          idle_run = 0;
        end
        smp.push_back(txd);
        if (smp.size() == 10 * (tb_rate + 1)) decode_frame();
      end
    end
  end

  // ---------------- CRU access ----------------
  task automatic cru_write(input int bitn, input logic v);
    @(negedge clk);
    a = (Base + 16'(2 * bitn)) | 16'(v);
    cruclk = 1'b1;
    @(negedge clk);
    cruclk = 1'b0;
  endtask

  task automatic cru_read(input int bitn, output logic v);
    @(negedge clk);
    a = Base + 16'(2 * bitn);
    #1;
    v = cruin;
  endtask

  task automatic check_bit(input string name, input int bitn, input logic exp);
    logic r;
    cru_read(bitn, r);
    check(name, 32'(r), 32'(exp));
  endtask

  task automatic wait_bit(input string name, input int bitn, input logic v, input int limit);
    logic r;
    int   n;
    n = 0;
    do begin
      cru_read(bitn, r);
      n++;
    end while (r !== v && n < limit);
    check(name, 32'(r), 32'(v));
  endtask

  task automatic set_rate(input logic [10:0] r);
    cru_write(12, 1'b1);
    for (int i = 0; i <= 10; i++) cru_write(i, r[i]);
    tb_rate = int'(r);
  endtask

  task automatic send_tx(input logic [7:0] d, input logic b2b);
    tx_q.push_back({d, b2b});
    for (int i = 0; i < 8; i++) cru_write(i, d[i]);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    int w;
    w = tb_rate + 1;
    rx_q.push_back({d, !stop});
    @(tick_ev);
    rxd = 1'b0;
    wait_ticks(w);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(w);
    end
    rxd = stop;
    wait_ticks(w);
    rxd = 1'b1;
    wait_ticks(w);
  endtask

  task automatic check_rx();
    rx_exp_t    e;
    logic [7:0] got;
    logic       r;
    if (rx_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_queue: got empty queue, expected a pending character");
      return;
    end
    e = rx_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      cru_read(i, r);
      got[i] = r;
    end
    check("rx_rbr", 32'(got), 32'(e.data));
    check_bit("rx_fe", 9, e.fe);
    check_bit("rx_rbrl", 21, 1'b1);
    check_bit("rx_int_bit", 31, tb_rienb);
    check("rx_irq", 32'(irq), 32'(tb_rienb));
    cru_write(18, tb_rienb);
    check_bit("rx_rbrl_clr", 21, 1'b0);
    check("rx_irq_clr", 32'(irq), 32'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int         n;

    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    check_bit("rst_xbre", 22, 1'b1);
    check_bit("rst_xsre", 23, 1'b1);
    check_bit("rst_rbrl", 21, 1'b0);

    // Address decode edges
    @(negedge clk);
    a = Base + 16'd44;
    #1 check("sel_xbre", {30'd0, cru_select, cruin}, 32'h3);
    a = 16'h1380;
    #1 check("sel_above", {30'd0, cru_select, cruin}, 32'h0);
    a = 16'h133E;
    #1 check("sel_below", {30'd0, cru_select, cruin}, 32'h0);
    a = Base + 16'd62;
    #1 check("sel_top", 32'(cru_select), 32'h1);

    // Directed transmit
    set_rate(11'd3);
    send_tx(8'hA5, 1'b0);
    check_bit("tx_xbre_after_load", 22, 1'b1);
    check_bit("tx_xsre_busy", 23, 1'b0);
    wait_bit("tx_xsre_done", 23, 1'b1, 1000);

    // Directed receive with interrupt enabled
    cru_write(18, 1'b1);
    tb_rienb = 1'b1;
    send_rx(8'h3C, 1'b1);
    check_rx();

    // Framing error then recovery
    send_rx(8'h55, 1'b0);
    check_rx();
    send_rx(8'($urandom), 1'b1);
    check_rx();

    // One-tick glitch is not a character
    set_rate(11'd7);
    @(tick_ev);
    rxd = 1'b0;
    @(tick_ev);
    rxd = 1'b1;
    wait_ticks(24);
    check_bit("glitch_rbrl", 21, 1'b0);
    send_rx(8'($urandom), 1'b1);
    check_rx();

    // Randomised rates and characters
    for (int it = 0; it < 5; it++) begin
      set_rate(11'($urandom_range(1, 5)));
      send_tx(8'($urandom), 1'b0);
      wait_bit("rnd_tx_done", 23, 1'b1, 2000);
      send_rx(8'($urandom), $urandom_range(0, 3) != 0);
      check_rx();
    end

    // Back-to-back frames
    set_rate(11'd2);
    send_tx(8'($urandom), 1'b0);
    wait_bit("b2b_first_loaded", 22, 1'b1, 50);
    send_tx(8'($urandom), 1'b1);
    check_bit("b2b_pending", 22, 1'b0);
    wait_bit("b2b_done", 23, 1'b1, 2000);

    // Soft reset mid-frame
    send_tx(8'($urandom), 1'b0);
    wait_ticks(12);
    cru_write(31, 1'b0);
    mon_flush = 1'b1;
    tb_rienb  = 1'b0;
    check("srst_txd", 32'(txd), 32'h1);
    check_bit("srst_xbre", 22, 1'b1);
    check_bit("srst_xsre", 23, 1'b1);
    repeat (2) @(negedge clk);

    // Divisor survives soft reset; monitor decodes at the retained rate
    send_tx(8'($urandom), 1'b0);
    wait_bit("post_srst_tx_done", 23, 1'b1, 2000);
    send_rx(8'($urandom), 1'b1);
    check_rx();

    n = 0;
    while (tx_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tx_queue_drained", 32'(tx_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
